// File: rtl/proc_w.sv
// W-bit multicycle bus processor: eight general registers, A/G ALU latches,
// a single shared bus, and a four-state T0..T3 sequencer under a Run/Done handshake.
module proc_w #(
    parameter int W = 9
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [W-1:0] DIN,
    output logic         Done,
    output logic [W-1:0] BusWires
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    // Bus source select bit positions: R0..R7 occupy 0..7.
    localparam int SEL_DIN = 8;
    localparam int SEL_G   = 9;

    state_t         state_q, state_d;
    logic [8:0]     ir_q, ir_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   g_q, g_d;
    logic [W-1:0]   r_q [8];
    logic [W-1:0]   r_d [8];

    logic [2:0]     opcode;
    logic [2:0]     rx;
    logic [2:0]     ry;
    logic [9:0]     bus_sel;
    logic           rx_in;
    logic           a_in;
    logic           g_in;
    logic           done_c;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   bus_terms [10];
    logic [W-1:0]   bus_value;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // Control decode: one-hot bus select, load enables and next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        bus_sel = '0;
        rx_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[8:0];
                    state_d = T1;
                end
            end
            T1: begin
                unique case (opcode)
                    OP_MV: begin
                        bus_sel[ry] = 1'b1;
                        rx_in       = 1'b1;
                        done_c      = 1'b1;
                        state_d     = T0;
                    end
                    OP_MVI: begin
                        bus_sel[SEL_DIN] = 1'b1;
                        rx_in            = 1'b1;
                        done_c           = 1'b1;
                        state_d          = T0;
                    end
                    OP_MVNZ: begin
                        bus_sel[ry] = 1'b1;
                        rx_in       = (g_q != '0);
                        done_c      = 1'b1;
                        state_d     = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        bus_sel[rx] = 1'b1;
                        a_in        = 1'b1;
                        state_d     = T2;
                    end
                    default: begin
                        done_c  = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel[ry] = 1'b1;
                g_in        = 1'b1;
                state_d     = T3;
            end
            T3: begin
                bus_sel[SEL_G] = 1'b1;
                rx_in          = 1'b1;
                done_c         = 1'b1;
                state_d        = T0;
            end
            default: state_d = T0;
        endcase
    end

    // Bus is an AND-OR of the one-hot selected sources; nothing selected yields 0.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bus_regs
            assign bus_terms[gi] = bus_sel[gi] ? r_q[gi] : '0;
        end
    endgenerate
    assign bus_terms[SEL_DIN] = bus_sel[SEL_DIN] ? DIN : '0;
    assign bus_terms[SEL_G]   = bus_sel[SEL_G]   ? g_q : '0;

    always_comb begin
        bus_value = '0;
        for (int i = 0; i < 10; i++) begin
            bus_value = bus_value | bus_terms[i];
        end
    end

    always_comb begin
        alu_result = '0;
        unique case (opcode)
            OP_ADD:  alu_result = a_q + bus_value;
            OP_SUB:  alu_result = a_q - bus_value;
            OP_AND:  alu_result = a_q & bus_value;
            OP_XOR:  alu_result = a_q ^ bus_value;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        a_d = a_in ? bus_value : a_q;
        g_d = g_in ? alu_result : g_q;
        for (int i = 0; i < 8; i++) begin
            r_d[i] = (rx_in && (rx == 3'(i))) ? bus_value : r_q[i];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    assign Done     = done_c;
    assign BusWires = bus_value;

endmodule

// File: doc/proc_w.md
# proc_w

Parametrised successor to the team's 9-bit multicycle bus processor. It is a W-bit datapath with eight general registers R0–R7, an A operand latch, a G result register, an instruction register, and a single shared bus. Instructions arrive on DIN under a Run/Done handshake. The instruction set is extended beyond mv/mvi/add/sub with a conditional move (mvnz) and two logic operations (and, xor). It sits between the instruction source (ROM/counter or switches) and whatever observes BusWires.

## Interface
- W, 9: datapath width in bits; legal range 9–32. Instruction field always lives in DIN[8:0].
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Run  in  1  start request; sampled only in state T0.
- DIN  in  W  instruction word in T0; immediate operand in T1 for mvi.
- Done  out  1  high during the final cycle of every instruction.
- BusWires  out  W  shared bus value; this is also the observation port.

## Operation
- Instruction format: DIN[8:6] = opcode, DIN[5:3] = X, DIN[2:0] = Y. DIN[W-1:9] are ignored when loading IR.
- Opcodes:
  - 000 mv: RX ← RY.
  - 001 mvi: RX ← DIN.
  - 010 add: RX ← RX + RY.
  - 011 sub: RX ← RX − RY.
  - 100 mvnz: RX ← RY only if G ≠ 0.
  - 101 and: RX ← RX & RY.
  - 110 xor: RX ← RX ^ RY.
  - 111 nop.
- Arithmetic is modulo 2^W. No carry or overflow is kept; sub wraps, e.g. 0 − 1 = all-ones.
- Bus sources are one-hot: DIN, R0–R7, G. When no source is selected the bus drives 0. At most one source is selected in any cycle.
- Register writes use decoded X: RXin loads RX from the bus on the rising edge. A loads in T1 of ALU ops. G loads the ALU result in T2.
- FSM states: T0, T1, T2, T3.
  - T0: if Run=1, IR ← DIN[8:0] and go to T1; otherwise stay in T0. No register other than IR changes in T0.
  - T1:
    - mv: bus = RY, RXin, Done; next T0.
    - mvi: bus = DIN, RXin, Done; next T0.
    - mvnz: bus = RY, RXin only if G ≠ 0, Done; next T0.
    - nop: Done; next T0.
    - add/sub/and/xor: bus = RX, Ain; next T2.
  - T2: bus = RY, Gin with ALU op selected by opcode; next T3.
  - T3: bus = G, RXin, Done; next T0.
- Run is ignored in T1–T3. The instruction completes regardless of Run.
- X = Y is legal. For example, add R2,R2 doubles R2, and mv R3,R3 is a no-op write.
- mvnz tests the value of G as it stands at the start of the T1 cycle, i.e. the result of the last ALU op.

## Timing
- Latency from the Run-sampling edge: mv/mvi/mvnz/nop take 1 cycle (Done in T1); ALU ops take 3 cycles (Done in T3).
- Done is combinational from state and IR. It is high for exactly one cycle per instruction and never in T0.
- Back-to-back issue: Run=1 in the T0 cycle following Done starts the next instruction with no bubble. Issue rate is 2 cycles per mv-class instruction and 4 cycles per ALU op.
- Reset values:
  - FSM: T0.
  - IR, A, G, R0–R7: 0.
  - Done: 0.
  - BusWires: 0.
- Reset mid-instruction aborts immediately: no partial RX write survives, and the FSM restarts in T0 after release.
- The destination register updates on the clock edge that ends the Done cycle. The new value is visible on the bus from the next cycle that selects it.

## Test plan
- Reset, then Run with mvi R0 (DIN=9'o100) followed by DIN=5 in T1 → Done high in T1; a later mv R1,R0 drives BusWires=5 in its T1 and leaves R1=5.
- R0=5, R1=7: add R0,R1 (9'o201) → BusWires shows 5, then 7, then 12 in T3; Done only in T3; R0=12.
- R0=3, R1=4: sub R0,R1 → R0=9'h1FF (wrap). Repeat with W=16 → R0=16'hFFFF.
- G=0, then mvnz R2,R3 with R3=9 → R2 unchanged. Then run add to make G≠0 and repeat mvnz → R2=9.
- Logic ops with R4=9'h0F0, R5=9'h1CC: and R4,R5 → 9'h0C0; xor R4,R5 from the original values → 9'h13C.
- Assert Reset during T2 of an add → all registers 0, Done 0, state T0; Run held high issues cleanly afterward. Also check that holding Run=0 in T0 leaves all registers stable for 10 cycles.
